// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
package mul_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Add32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group
// generate/propagate, exporting the overall generate and propagate so the
// caller forms its own carry-out.
module Add32
    import mul_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_in_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             g_out_o,
    output logic             p_out_o
);

    // Returns {group generate, group propagate, sum} for x + y + cin.
    function automatic logic [WIDTH+1:0] claAdd(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] s;
        logic [3:0]       gk;
        logic [3:0]       pk;
        logic [3:0]       ck;
        logic             c;
        logic             gg;
        logic             pg;
        logic             gAll;
        logic             pAll;
        g    = x & y;
        p    = x ^ y;
        s    = '0;
        c    = cin;
        gAll = 1'b0;
        pAll = 1'b1;
        for (int k = 0; k < WIDTH / 4; k++) begin
            gk    = g[4*k +: 4];
            pk    = p[4*k +: 4];
            ck[0] = c;
            ck[1] = gk[0] | (pk[0] & c);
            ck[2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & c);
            ck[3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                  | (pk[2] & pk[1] & pk[0] & c);
            gg    = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                  | (pk[3] & pk[2] & pk[1] & gk[0]);
            pg    = &pk;
            s[4*k +: 4] = pk ^ ck;
            c    = gg | (pg & c);
            gAll = gg | (pg & gAll);
            pAll = pAll & pg;
        end
        return {gAll, pAll, s};
    endfunction

    // Purely combinational sum plus whole-word generate/propagate.
    always_comb begin
        {g_out_o, p_out_o, sum_o} = claAdd(a_i, b_i, carry_in_i);
    end

endmodule

// File: rtl/mul32_seq.sv
// Unsigned 32x32->64 shift-and-add multiplier. One partial product per clock
// goes through the shared Add32; the carry-out lands in the top bit of hi so
// the full 64-bit result is exact.
module mul32_seq
    import mul_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam logic ADD_CIN = 1'b0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               gOut;
    logic               pOut;
    logic               stepCarry;

    // The multiplicand is added only when the multiplier bit now in lo[0] is set.
    always_comb begin
        addend    = lo_q[0] ? mcand_q : '0;
        stepCarry = gOut | (pOut & ADD_CIN);
    end

    Add32 u_add (
        .a_i        (hi_q),
        .b_i        (addend),
        .carry_in_i (ADD_CIN),
        .sum_o      (sum),
        .g_out_o    (gOut),
        .p_out_o    (pOut)
    );

    // Next-state logic: load on accept, shift {carry, sum, lo} right each RUN step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                hi_d  = {stepCarry, sum[WIDTH-1:1]};
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign product   = {hi_q, lo_q};

endmodule
